// File: rtl/uram_burst_reader.sv
// Burst read initiator for one URAM port: issues single-word reads, absorbs the
// 1-cycle read latency in a 2-entry FIFO and streams words out with a last marker.
module uram_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready high
  // READ  | issuing reads while words remain to be issued
  // DRAIN | all reads issued; waiting for the last beat to leave
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic       pop;
  logic       issue;
  logic [2:0] occupancy;

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    done_d      = 1'b0;

    m_valid   = (count_q != 2'd0);
    m_data    = fifo_q[rd_ptr_q];
    m_last    = m_valid & (beat_cnt_q == LEN_ONE);
    req_ready = (state_q == IDLE);
    pop       = m_valid & m_ready;

    // Reads already committed (buffered or in flight) after this cycle's pop.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == READ) && (issue_cnt_q != '0) && (occupancy < 3'd2);

    mem_ce     = issue;
    mem_we     = 1'b0;
    mem_addr   = issue ? addr_cnt_q : '0;
    inflight_d = issue;

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      beat_cnt_d = beat_cnt_q - LEN_ONE;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_cnt_d  = req_addr;
          issue_cnt_d = req_len;
          beat_cnt_d  = req_len;
          if (req_len == '0) done_d = 1'b1;
          else               state_d = READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_cnt_d  = addr_cnt_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          if (issue_cnt_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    done = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      fifo_q      <= '{default: '0};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uram_burst_reader.sv
// Directed bench for uram_burst_reader with a 1-cycle-latency URAM model
// and a stream monitor checking ordering, stall stability and issue bounds.
module tb_uram_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [12:0] req_len;
  logic        mem_ce;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  uram_burst_reader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:4095];

  function automatic logic [63:0] exp_word(input logic [11:0] a);
    if (a >= 12'h010 && a <= 12'h013) return 64'hA0 + 64'(a - 12'h010);
    return {32'hC0DE_0000, 20'h0, a};
  endfunction

  always @(posedge clk) if (mem_ce) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor
  logic [64:0] beat_q [$];
  logic [11:0] addr_q [$];
  int          ce_cnt = 0;
  int          done_cnt = 0;
  int          outst = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data = '0;
  int          pop_i;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst      = 0;
      stall_prev = 1'b0;
    end else begin
      pop_i = (m_valid && m_ready) ? 1 : 0;
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_data);
      end
      if (mem_ce) begin
        chk("issue_bound", (outst - pop_i) < 2, 1);
        addr_q.push_back(mem_addr);
        ce_cnt++;
      end
      if (pop_i != 0) beat_q.push_back({m_last, m_data});
      if (done) done_cnt++;
      outst      = outst + (mem_ce ? 1 : 0) - pop_i;
      stall_prev = m_valid & ~m_ready;
      stall_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_q.delete();
    addr_q.delete();
    ce_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic request(input logic [11:0] a, input logic [12:0] n);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
  endtask

  localparam logic [31:0] BP_PAT = 32'hB5C3_96A4;

  task automatic wait_done(input int bound, input bit bp);
    logic [31:0] pat;
    bit seen;
    pat  = BP_PAT;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bp) m_ready = pat[i % 32];
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    chk("done_seen", seen, 1);
  endtask

  task automatic chk_beats(input int first, input int n, input logic [11:0] base, input bit last_at_end);
    logic [64:0] b;
    for (int i = 0; i < n; i++) begin
      if (first + i < beat_q.size()) begin
        b = beat_q[first + i];
        chk("beat_data", b[63:0], exp_word(base + 12'(i)));
        chk("beat_last", b[64], (last_at_end && i == n - 1) ? 1 : 0);
      end else begin
        chk("beat_missing", 0, 1);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = exp_word(12'(a));
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; m_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();

    // Basic burst: accept in T, check T+1, T+3, T+6, T+7
    clear_mon();
    request(12'h010, 13'd4);
    tick();
    req_valid = 1'b0;
    chk("basic_ce_t1", mem_ce, 1);
    chk("basic_addr_t1", mem_addr, 12'h010);
    chk("basic_rdy_t1", req_ready, 0);
    tick(); tick();
    chk("basic_valid_t3", m_valid, 1);
    chk("basic_data_t3", m_data, 64'hA0);
    chk("basic_last_t3", m_last, 0);
    tick(); tick(); tick();
    chk("basic_data_t6", m_data, 64'hA3);
    chk("basic_last_t6", m_last, 1);
    tick();
    chk("basic_done_t7", done, 1);
    chk("basic_rdy_t7", req_ready, 1);
    chk("basic_valid_t7", m_valid, 0);
    tick();
    chk("basic_done_t8", done, 0);
    chk("basic_ce_cnt", ce_cnt, 4);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_beats", beat_q.size(), 4);
    chk_beats(0, 4, 12'h010, 1'b1);

    // Wrap-around
    clear_mon();
    request(12'hFFE, 13'd4);
    tick();
    req_valid = 1'b0;
    wait_done(30, 1'b0);
    chk("wrap_addr_cnt", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("wrap_addr0", addr_q[0], 12'hFFE);
      chk("wrap_addr1", addr_q[1], 12'hFFF);
      chk("wrap_addr2", addr_q[2], 12'h000);
      chk("wrap_addr3", addr_q[3], 12'h001);
    end
    chk("wrap_beats", beat_q.size(), 4);
    chk_beats(0, 4, 12'hFFE, 1'b1);

    // Backpressure
    tick();
    clear_mon();
    request(12'h100, 13'd16);
    tick();
    req_valid = 1'b0;
    wait_done(200, 1'b1);
    chk("bp_ce_cnt", ce_cnt, 16);
    chk("bp_beats", beat_q.size(), 16);
    chk_beats(0, 16, 12'h100, 1'b1);
    tick();
    chk("bp_done_cnt", done_cnt, 1);

    // Zero length
    clear_mon();
    request(12'h123, 13'd0);
    tick();
    req_valid = 1'b0;
    chk("zero_done_t1", done, 1);
    chk("zero_rdy_t1", req_ready, 1);
    chk("zero_ce_t1", mem_ce, 0);
    tick();
    chk("zero_done_t2", done, 0);
    tick(); tick();
    chk("zero_ce_cnt", ce_cnt, 0);
    chk("zero_beats", beat_q.size(), 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Reset mid-burst
    clear_mon();
    request(12'h200, 13'd32);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (beat_q.size() >= 5) break;
      tick();
    end
    chk("mid_beats5", beat_q.size(), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", req_ready, 1);
    chk("mid_rst_ce", mem_ce, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_no_done", done_cnt, 0);
    clear_mon();
    request(12'h300, 13'd2);
    tick();
    req_valid = 1'b0;
    wait_done(30, 1'b0);
    chk("mid_new_beats", beat_q.size(), 2);
    chk_beats(0, 2, 12'h300, 1'b1);

    // Back-to-back
    tick();
    clear_mon();
    request(12'h040, 13'd2);
    tick();
    req_valid = 1'b0;
    begin
      bit rdy_seen;
      rdy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (req_ready) begin
          rdy_seen = 1'b1;
          break;
        end
      end
      chk("b2b_rdy_back", rdy_seen, 1);
    end
    chk("b2b_done_with_rdy", done, 1);
    request(12'h050, 13'd3);
    tick();
    req_valid = 1'b0;
    chk("b2b_ce_next", mem_ce, 1);
    chk("b2b_addr_next", mem_addr, 12'h050);
    chk("b2b_rdy_low", req_ready, 0);
    wait_done(30, 1'b0);
    chk("b2b_beats", beat_q.size(), 5);
    chk_beats(0, 2, 12'h040, 1'b1);
    chk_beats(2, 3, 12'h050, 1'b1);
    tick();
    chk("b2b_done_cnt", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
